// File: rtl/rom_ddr_pkg.sv
// Shared types and helpers for the ROM-to-DDRAM responder.
// Lane k of a 64-bit DDRAM line holds the 16-bit ROM word at bits [16k+15:16k].
package rom_ddr_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WR     = 2'd1,
      ST_RD     = 2'd2,
      ST_RDWAIT = 2'd3
   } state_t;

   localparam logic [7:0] BURSTCNT = 8'd1;
   localparam int         TAG_W    = 20;

   function automatic logic [15:0] lane_sel(input logic [63:0] line, input logic [1:0] k);
      logic [15:0] word;
      case (k)
         2'd0:    word = line[15:0];
         2'd1:    word = line[31:16];
         2'd2:    word = line[47:32];
         default: word = line[63:48];
      endcase
      return word;
   endfunction

   function automatic logic [7:0] be_gen(input logic [1:0] k);
      return 8'b0000_0011 << {k, 1'b0};
   endfunction

endpackage

// File: rtl/rom_line_cache.sv
// One-line 64-bit read cache: tag, valid flag and line register.
// Invalidate wins over a fill on the same edge.
module rom_line_cache
   import rom_ddr_pkg::*;
(
   input  logic             clk_sys,
   input  logic             reset_n,
   input  logic             i_inv,
   input  logic             i_fill,
   input  logic [TAG_W-1:0] i_fill_tag,
   input  logic [63:0]      i_fill_line,
   input  logic [TAG_W-1:0] i_tag,
   output logic             o_hit,
   output logic [63:0]      o_line
);

   logic             r_valid;
   logic [TAG_W-1:0] r_tag;
   logic [63:0]      r_line;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_valid <= 1'b0;
         r_tag   <= '0;
         r_line  <= '0;
      end else if (i_inv) begin
         r_valid <= 1'b0;
      end else if (i_fill) begin
         r_valid <= 1'b1;
         r_tag   <= i_fill_tag;
         r_line  <= i_fill_line;
      end
   end

   assign o_hit  = r_valid && (r_tag == i_tag);
   assign o_line = r_line;

endmodule

// File: rtl/rom_ddr_responder.sv
// Toggle req/ack ROM responder driving single-beat DDRAM reads and writes.
// Optional one-line read cache enabled by defining ROMDDR_CACHE_EN.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   ST_IDLE   | waiting for a pending write or read (cache hits served here)
//   ST_WR     | DDRAM_WE asserted, waiting for BUSY low
//   ST_RD     | DDRAM_RD asserted, waiting for BUSY low
//   ST_RDWAIT | read accepted, waiting for DDRAM_DOUT_READY
module rom_ddr_responder
   import rom_ddr_pkg::*;
#(
   parameter logic [28:0] BASE_ADDR = 29'h0600000
)
(
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic [24:0] wraddr,
   input  logic [15:0] din,
   input  logic        we_req,
   output logic        we_ack,
   input  logic [22:1] rdaddr,
   output logic [15:0] dout,
   input  logic        rd_req,
   output logic        rd_ack,
   input  logic        DDRAM_BUSY,
   output logic [7:0]  DDRAM_BURSTCNT,
   output logic [28:0] DDRAM_ADDR,
   input  logic [63:0] DDRAM_DOUT,
   input  logic        DDRAM_DOUT_READY,
   output logic        DDRAM_RD,
   output logic [63:0] DDRAM_DIN,
   output logic [7:0]  DDRAM_BE,
   output logic        DDRAM_WE
);

   state_t      r_state, w_state_nxt;
   logic        r_we_ack, r_rd_ack, r_rd, r_we;
   logic [15:0] r_dout;
   logic [28:0] r_addr;
   logic [63:0] r_din;
   logic [7:0]  r_be;

   logic        w_we_ack_nxt, w_rd_ack_nxt, w_rd_nxt, w_we_nxt;
   logic [15:0] w_dout_nxt;
   logic [28:0] w_addr_nxt;
   logic [63:0] w_din_nxt;
   logic [7:0]  w_be_nxt;

   logic             w_wr_pend, w_rd_pend;
   logic [1:0]       w_wr_k, w_rd_k;
   logic [TAG_W-1:0] w_rd_tag;
   logic [28:0]      w_wr_addr, w_rd_addr;
   logic             w_inv, w_fill;
   logic             w_hit;
   logic [15:0]      w_hit_word;
   logic             w_unused;

   assign w_wr_pend = we_req ^ r_we_ack;
   assign w_rd_pend = rd_req ^ r_rd_ack;
   assign w_wr_k    = wraddr[2:1];
   assign w_rd_k    = rdaddr[2:1];
   assign w_rd_tag  = rdaddr[22:3];
   assign w_wr_addr = BASE_ADDR | {7'd0, wraddr[24:3]};
   assign w_rd_addr = BASE_ADDR | {9'd0, w_rd_tag};

`ifdef ROMDDR_CACHE_EN
   logic [63:0] w_cache_line;

   rom_line_cache u_cache (
      .clk_sys     (clk_sys),
      .reset_n     (reset_n),
      .i_inv       (w_inv),
      .i_fill      (w_fill),
      .i_fill_tag  (w_rd_tag),
      .i_fill_line (DDRAM_DOUT),
      .i_tag       (w_rd_tag),
      .o_hit       (w_hit),
      .o_line      (w_cache_line)
   );

   assign w_hit_word = lane_sel(w_cache_line, w_rd_k);
   assign w_unused   = wraddr[0];
`else
   assign w_hit      = 1'b0;
   assign w_hit_word = 16'd0;
   assign w_unused   = &{1'b0, wraddr[0], w_inv, w_fill};
`endif

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= ST_IDLE;
         r_we_ack <= 1'b0;
         r_rd_ack <= 1'b0;
         r_rd     <= 1'b0;
         r_we     <= 1'b0;
         r_dout   <= '0;
         r_addr   <= '0;
         r_din    <= '0;
         r_be     <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_we_ack <= w_we_ack_nxt;
         r_rd_ack <= w_rd_ack_nxt;
         r_rd     <= w_rd_nxt;
         r_we     <= w_we_nxt;
         r_dout   <= w_dout_nxt;
         r_addr   <= w_addr_nxt;
         r_din    <= w_din_nxt;
         r_be     <= w_be_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_wr_pend)
               w_state_nxt = ST_WR;
            else if (w_rd_pend && !w_hit)
               w_state_nxt = ST_RD;
         end
         ST_WR:     if (!DDRAM_BUSY)      w_state_nxt = ST_IDLE;
         ST_RD:     if (!DDRAM_BUSY)      w_state_nxt = ST_RDWAIT;
         ST_RDWAIT: if (DDRAM_DOUT_READY) w_state_nxt = ST_IDLE;
         default:                         w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_we_ack_nxt = r_we_ack;
      w_rd_ack_nxt = r_rd_ack;
      w_rd_nxt     = r_rd;
      w_we_nxt     = r_we;
      w_dout_nxt   = r_dout;
      w_addr_nxt   = r_addr;
      w_din_nxt    = r_din;
      w_be_nxt     = r_be;
      w_inv        = 1'b0;
      w_fill       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_wr_pend) begin
               w_we_nxt   = 1'b1;
               w_addr_nxt = w_wr_addr;
               w_din_nxt  = {4{din}};
               w_be_nxt   = be_gen(w_wr_k);
               w_inv      = 1'b1;
            end else if (w_rd_pend) begin
               if (w_hit) begin
                  w_dout_nxt   = w_hit_word;
                  w_rd_ack_nxt = rd_req;
               end else begin
                  w_rd_nxt   = 1'b1;
                  w_addr_nxt = w_rd_addr;
               end
            end
         end
         ST_WR: begin
            if (!DDRAM_BUSY) begin
               w_we_nxt     = 1'b0;
               w_we_ack_nxt = we_req;
            end
         end
         ST_RD: begin
            if (!DDRAM_BUSY) w_rd_nxt = 1'b0;
         end
         ST_RDWAIT: begin
            if (DDRAM_DOUT_READY) begin
               w_fill       = 1'b1;
               w_dout_nxt   = lane_sel(DDRAM_DOUT, w_rd_k);
               w_rd_ack_nxt = rd_req;
            end
         end
         default: ;
      endcase
   end

   assign we_ack         = r_we_ack;
   assign rd_ack         = r_rd_ack;
   assign dout           = r_dout;
   assign DDRAM_RD       = r_rd;
   assign DDRAM_WE       = r_we;
   assign DDRAM_ADDR     = r_addr;
   assign DDRAM_DIN      = r_din;
   assign DDRAM_BE       = r_be;
   assign DDRAM_BURSTCNT = BURSTCNT;

endmodule
